// File: rtl/entrada_captura.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : entrada_captura
//  Description : Input-capture stage for the move decoder. Synchronises and
//                debounces seven code switches plus a confirm button, checks
//                each confirmed code against the legal move set and presents
//                it on Entrada with a one-cycle Controle strobe (Invalido for
//                illegal codes). Keeps a saturating count of accepted moves.
//  Revision    : 1.0 - initial release
// ============================================================================
module entrada_captura #(
    parameter int DEB_CYCLES = 1000,
    parameter int CNT_W      = 10
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [6:0] chaves,
    input  logic       confirma,
    output logic [6:0] Entrada,
    output logic       Controle,
    output logic       Invalido,
    output logic [7:0] Contagem
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EVAL     = 2'd1;
    localparam logic [1:0] S_WAIT_REL = 2'd2;

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_db;
    logic [1:0]       r_state;
    logic [6:0]       r_entrada;
    logic             r_controle;
    logic             r_invalido;
    logic [7:0]       r_contagem;
    logic             w_legal;

    // Membership test against the eight legal move codes
    function automatic logic f_legal(input logic [6:0] code);
        case (code)
            7'b1100000, 7'b1000100, 7'b1111100, 7'b1011010,
            7'b1101110, 7'b1110101, 7'b1001001, 7'b1010011: f_legal = 1'b1;
            default:                                        f_legal = 1'b0;
        endcase
    endfunction

    // Legality of the code currently held in the debounced vector
    always_comb begin
        w_legal = f_legal(r_db[6:0]);
    end

    // Two-flop synchroniser for {confirma, chaves}, plus one-cycle history
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_sync1 <= 8'd0;
            r_sync2 <= 8'd0;
            r_prev  <= 8'd0;
        end else begin
            r_sync1 <= {confirma, chaves};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Shared debounce: any change restarts the wait, DEB_CYCLES stable samples commit
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_cnt <= '0;
            r_db  <= 8'd0;
        end else if (r_sync2 != r_prev) begin
            r_cnt <= '0;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_db  <= r_sync2;
        end
    end

    // Capture FSM. The evaluation result is registered on the edge that enters
    // S_EVAL, so the strobe and the new Entrada are visible during S_EVAL,
    // one cycle after the debounced button first reads high.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_entrada  <= 7'd0;
            r_controle <= 1'b0;
            r_invalido <= 1'b0;
            r_contagem <= 8'd0;
        end else begin
            r_controle <= 1'b0;
            r_invalido <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_db[7]) begin
                        r_state <= S_EVAL;
                        if (w_legal) begin
                            r_entrada  <= r_db[6:0];
                            r_controle <= 1'b1;
                            if (r_contagem != 8'hFF) begin
                                r_contagem <= r_contagem + 8'd1;
                            end
                        end else begin
                            r_invalido <= 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    r_state <= S_WAIT_REL;
                end
                S_WAIT_REL: begin
                    if (!r_db[7]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Entrada  = r_entrada;
    assign Controle = r_controle;
    assign Invalido = r_invalido;
    assign Contagem = r_contagem;

endmodule
`default_nettype wire

// File: tb/tb_entrada_captura.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_entrada_captura
//  Description : Self-checking bench for entrada_captura (DEB_CYCLES=4,
//                CNT_W=3): table of single presses plus hand-written
//                sequences for bounce, hold, reset-abort and saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_entrada_captura;

    logic       clk = 1'b0;
    logic       Reset;
    logic [6:0] chaves;
    logic       confirma;
    logic [6:0] Entrada;
    logic       Controle;
    logic       Invalido;
    logic [7:0] Contagem;

    entrada_captura #(.DEB_CYCLES(4), .CNT_W(3)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .chaves   (chaves),
        .confirma (confirma),
        .Entrada  (Entrada),
        .Controle (Controle),
        .Invalido (Invalido),
        .Contagem (Contagem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] code;
        logic [6:0] exp_ent;
        int         exp_ctrl;
        int         exp_inv;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [9];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_ctrl = 0;
    int n_inv  = 0;
    int n_viol = 0;

    logic       prev_c   = 1'b0;
    logic       prev_i   = 1'b0;
    logic       prev_rst = 1'b1;
    logic [6:0] prev_ent = 7'd0;

    // Strobe monitor: counts pulses and records rule violations
    always @(negedge clk) begin
        if (Controle === 1'b1) n_ctrl <= n_ctrl + 1;
        if (Invalido === 1'b1) n_inv  <= n_inv + 1;
        if ((Controle === 1'b1 && Invalido === 1'b1) ||
            (Controle === 1'b1 && prev_c) ||
            (Invalido === 1'b1 && prev_i) ||
            (Reset === 1'b0 && !prev_rst && Controle !== 1'b1 && Entrada !== prev_ent))
            n_viol <= n_viol + 1;
        prev_c   <= (Controle === 1'b1);
        prev_i   <= (Invalido === 1'b1);
        prev_rst <= (Reset !== 1'b0);
        prev_ent <= Entrada;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [6:0] code, output int dc, output int di);
        int c0;
        int i0;
        c0 = n_ctrl;
        i0 = n_inv;
        chaves = code;
        wait_cyc(8);
        confirma = 1'b1;
        wait_cyc(12);
        confirma = 1'b0;
        wait_cyc(12);
        dc = n_ctrl - c0;
        di = n_inv - i0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        int di;
        int c0;
        int k;

        vecs[0] = '{7'b1100000, 7'b1100000, 1, 0, 8'd1};
        vecs[1] = '{7'b0101010, 7'b1100000, 0, 1, 8'd1};
        vecs[2] = '{7'b1011010, 7'b1011010, 1, 0, 8'd2};
        vecs[3] = '{7'b0000000, 7'b1011010, 0, 1, 8'd2};
        vecs[4] = '{7'b1110101, 7'b1110101, 1, 0, 8'd3};
        vecs[5] = '{7'b1111111, 7'b1110101, 0, 1, 8'd3};
        vecs[6] = '{7'b1001001, 7'b1001001, 1, 0, 8'd4};
        vecs[7] = '{7'b1010011, 7'b1010011, 1, 0, 8'd5};
        vecs[8] = '{7'b1101110, 7'b1101110, 1, 0, 8'd6};

        // Reset with toggling inputs
        Reset    = 1'b1;
        chaves   = 7'b1010101;
        confirma = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chaves   = ~chaves;
            confirma = ~confirma;
        end
        Reset    = 1'b0;
        chaves   = 7'd0;
        confirma = 1'b0;
        @(negedge clk);
        chk("reset Entrada", Entrada, 7'd0);
        chk("reset Controle", Controle, 1'b0);
        chk("reset Invalido", Invalido, 1'b0);
        chk("reset Contagem", Contagem, 8'd0);
        wait_cyc(10);

        // Table of single presses
        for (int i = 0; i < 9; i++) begin
            press(vecs[i].code, dc, di);
            chk($sformatf("row%0d Controle pulses", i), dc, vecs[i].exp_ctrl);
            chk($sformatf("row%0d Invalido pulses", i), di, vecs[i].exp_inv);
            chk($sformatf("row%0d Entrada", i), Entrada, vecs[i].exp_ent);
            chk($sformatf("row%0d Contagem", i), Contagem, vecs[i].exp_cnt);
        end
        chk("strobe rules after table", n_viol, 0);

        // Bouncing confirm: no capture until it settles
        chaves = 7'b1011010;
        wait_cyc(8);
        c0 = n_ctrl;
        repeat (5) begin
            confirma = 1'b1; wait_cyc(2);
            confirma = 1'b0; wait_cyc(2);
        end
        chk("bounce no pulse", n_ctrl - c0, 0);
        confirma = 1'b1;
        wait_cyc(12);
        chk("bounce single pulse", n_ctrl - c0, 1);
        chk("bounce Entrada", Entrada, 7'b1011010);
        chk("bounce Contagem", Contagem, 8'd7);
        confirma = 1'b0;
        wait_cyc(12);

        // Exact latency, then switch change while held, then second press
        chaves = 7'b1000100;
        wait_cyc(8);
        c0 = n_ctrl;
        confirma = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("latency Controle early", Controle, 1'b0);
        @(negedge clk);
        chk("latency Controle on time", Controle, 1'b1);
        chk("latency Entrada", Entrada, 7'b1000100);
        chk("latency Contagem", Contagem, 8'd8);
        @(negedge clk);
        chk("latency Controle width", Controle, 1'b0);
        wait_cyc(4);
        chaves = 7'b1111100;
        wait_cyc(12);
        chk("hold change no pulse", n_ctrl - c0, 1);
        chk("hold change Entrada", Entrada, 7'b1000100);
        confirma = 1'b0;
        wait_cyc(12);
        confirma = 1'b1;
        wait_cyc(12);
        confirma = 1'b0;
        wait_cyc(12);
        chk("second press pulses", n_ctrl - c0, 2);
        chk("second press Entrada", Entrada, 7'b1111100);
        chk("second press Contagem", Contagem, 8'd9);

        // Reset in the cycle the debounced button rises: no strobe
        c0 = n_ctrl + n_inv;
        confirma = 1'b1;
        k = 0;
        @(negedge clk);
        while (dut.r_db[7] !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("db rise seen", (k < 40), 1'b1);
        #2;
        Reset    = 1'b1;
        confirma = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        Reset = 1'b0;
        wait_cyc(20);
        chk("reset abort no strobe", n_ctrl + n_inv - c0, 0);
        chk("reset abort Entrada", Entrada, 7'd0);
        chk("reset abort Contagem", Contagem, 8'd0);

        // Saturation of the accepted-move count
        c0 = n_ctrl;
        for (int p = 1; p <= 256; p++) begin
            press(7'b1001001, dc, di);
            chk($sformatf("sat press %0d Contagem", p), Contagem, (p > 255) ? 255 : p);
        end
        chk("sat pulses", n_ctrl - c0, 256);
        chk("sat Entrada", Entrada, 7'b1001001);
        chk("strobe rules overall", n_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
